// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: time-shares one single-port synchronous-read RAM between
// instruction fetch and load/store. Each access takes IDLE -> ACCESS -> WAIT,
// with the ack pulsing in the cycle after WAIT. Data has priority, but after
// MAX_DATA_RUN back-to-back data grants with fetch waiting, fetch gets the port.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t     state, state_nxt;
    logic       grant_d, grant_f;
    logic       d_bad;
    logic       owner_d;     // 1 = current access belongs to the data port
    logic       we_q;
    logic       err_q;
    logic [3:0] run_cnt;     // consecutive data grants while fetch was waiting

    // Fetch ignores the byte offset and the bits above the RAM depth.
    logic unused_if_bits;
    assign unused_if_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2]};

    // A data access is rejected when it is misaligned or falls outside the RAM.
    assign d_bad = (d_addr[1:0] != 2'b00) || ((d_addr >> (ADDR_W + 2)) != 32'd0);

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Arbitration and next state. Grants are only made from IDLE.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || run_cnt != RUN_MAX)) grant_d = 1'b1;
                else if (if_req)                               grant_f = 1'b1;
                if (grant_d || grant_f) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counter: grows on data grants that bypass a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (grant_f || !if_req)
                run_cnt <= 4'd0;
            else if (grant_d && run_cnt != 4'hF)
                run_cnt <= run_cnt + 4'd1;
        end
    end

    // Datapath: latch the granted request, drive the RAM, return data and acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            if_ack    <= 1'b0;
            if_rdata  <= 32'd0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'd0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A rejected access still runs the FSM so the ack timing
                        // is uniform, but never touches the RAM.
                        owner_d   <= 1'b1;
                        we_q      <= d_we;
                        err_q     <= d_bad;
                        mem_en    <= !d_bad;
                        mem_we    <= d_we && !d_bad;
                        mem_addr  <= d_addr[ADDR_W+1:2];
                        mem_wdata <= d_wdata;
                    end else if (grant_f) begin
                        owner_d   <= 1'b0;
                        we_q      <= 1'b0;
                        err_q     <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr[ADDR_W+1:2];
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                WAIT: begin
                    if (owner_d) begin
                        d_ack <= 1'b1;
                        d_err <= err_q;
                        if (!we_q && !err_q) d_rdata <= mem_rdata;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    logic [31:0]       ram [0:(1<<ADDR_W)-1] = '{default: 32'd0};
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // RAM model with a bench-side preload port.
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One data access, called at a negedge in IDLE; returns what was seen.
    task automatic d_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int en_n, output int we_n,
                          output logic [31:0] a_seen, output logic err);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        lat = 0; en_n = 0; we_n = 0; a_seen = 32'd0; err = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en) begin en_n++; a_seen = 32'(mem_addr); end
            if (mem_we) we_n++;
        end while (!d_ack && lat < 10);
        err = d_err;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
    endtask

    int          lat, en_n, we_n, nack, cyc, last, gap_bad, both, acks;
    logic [31:0] a_seen;
    logic        err;
    logic [9:0]  seq;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
        repeat (2) @(negedge clk);
        ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'h00500093;
        @(negedge clk);
        ld_en = 1'b0;
        chk("rst_ctl", {26'd0, if_ack, d_ack, d_err, mem_en, mem_we, busy}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only
        if_req = 1'b1; if_addr = 32'h8;
        @(negedge clk);
        chk("f_en", {31'd0, mem_en}, 32'd1);
        chk("f_addr", 32'(mem_addr), 32'd2);
        chk("f_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("f_en_off", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        chk("f_ack", {31'd0, if_ack}, 32'd1);
        chk("f_rdata", if_rdata, 32'h00500093);
        if_req = 1'b0;
        @(negedge clk);
        chk("f_ack_pulse", {31'd0, if_ack}, 32'd0);
        chk("f_idle", {31'd0, busy}, 32'd0);

        // Store then load
        d_xfer(1'b1, 32'h40, 32'hDEADBEEF, lat, en_n, we_n, a_seen, err);
        chk("st_lat", lat, 3);
        chk("st_en_n", en_n, 1);
        chk("st_we_n", we_n, 1);
        chk("st_addr", a_seen, 32'h10);
        chk("st_err", {31'd0, err}, 32'd0);
        chk("st_ram", ram[16], 32'hDEADBEEF);
        d_xfer(1'b0, 32'h40, 32'd0, lat, en_n, we_n, a_seen, err);
        chk("ld_lat", lat, 3);
        chk("ld_we_n", we_n, 0);
        chk("ld_rdata", d_rdata, 32'hDEADBEEF);
        chk("ld_err", {31'd0, err}, 32'd0);

        // Rejected accesses: misaligned load, out-of-range store
        d_xfer(1'b0, 32'h42, 32'd0, lat, en_n, we_n, a_seen, err);
        chk("mis_lat", lat, 3);
        chk("mis_en_n", en_n, 0);
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_rdata", d_rdata, 32'hDEADBEEF);
        d_xfer(1'b1, 32'h1000, 32'h55, lat, en_n, we_n, a_seen, err);
        chk("oor_lat", lat, 3);
        chk("oor_en_n", en_n, 0);
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_ram0", ram[0], 32'd0);
        chk("oor_rdata", d_rdata, 32'hDEADBEEF);

        // Contention: both held high, expect D,D,D,D,F repeating, an ack every 3 cycles
        if_addr = 32'h8; d_addr = 32'h40; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        nack = 0; cyc = 0; last = 0; gap_bad = 0; both = 0; seq = '0;
        while (nack < 10 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (if_ack || d_ack) begin
                seq[nack] = d_ack;
                if (if_ack && d_ack) both++;
                if (nack > 0 && cyc - last != 3) gap_bad++;
                last = cyc;
                nack++;
                if (nack == 10) begin if_req = 1'b0; d_req = 1'b0; end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("cnt_acks", nack, 10);
        chk("cnt_order", 32'(seq), 32'b0111101111);
        chk("cnt_gap", gap_bad, 0);
        chk("cnt_both", both, 0);
        chk("cnt_if_rdata", if_rdata, 32'h00500093);
        chk("cnt_d_rdata", d_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("cnt_idle", {31'd0, busy}, 32'd0);

        // Reset during ACCESS of a store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("rs_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        chk("rs_ctl", {26'd0, if_ack, d_ack, d_err, mem_en, mem_we, busy}, 32'd0);
        chk("rs_if_rdata", if_rdata, 32'd0);
        chk("rs_d_rdata", d_rdata, 32'd0);
        chk("rs_ram", ram[32], 32'h12345678);
        rst = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (d_ack || if_ack) acks++;
        end
        chk("rs_no_ack", acks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
